player_anim_ctrl: RTL and testbench

//  Animation sequencer and address generator for a 3-frame player sprite ROM (frames IDLE/THROW/HIT stacked).

---
 rtl/player_anim_ctrl_pkg.sv | 12 +
 rtl/player_anim_ctrl_if.sv | 33 +++
 rtl/player_anim_ctrl_addr_gen.sv | 46 ++++
 rtl/player_anim_ctrl.sv | 84 ++++++++
 tb/tb_player_anim_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/player_anim_ctrl_pkg.sv
// players_pkg: shared animation states, sprite geometry and ROM frame-base helper.
package players_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, THROW = 2'd1, HIT = 2'd2} anim_state_e;
    localparam int IMG_W = 140;
    localparam int IMG_H = 151;
    localparam int FRAME_WORDS = IMG_W * IMG_H;
    localparam int ROM_AW = 16;
    // Frames are stacked in ROM in enum order, so the base is a simple multiple.
    function automatic logic [ROM_AW-1:0] base(anim_state_e s);
        return ROM_AW'(FRAME_WORDS * int'(s));
    endfunction
endpackage

// File: rtl/player_anim_ctrl_if.sv
// player_anim_ctrl_if: game-logic/raster side and ROM-address side of one player's sprite.
// PLAYER_MIRROR_EN adds facing_left.
interface player_anim_ctrl_if;
    import players_pkg::*;
    logic frame_tick;
    logic throw_req;
    logic hit_req;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [10:0] xpos;
    logic [10:0] ypos;
`ifdef PLAYER_MIRROR_EN
    logic facing_left;
`endif
    logic [ROM_AW-1:0] rom_addr;
    logic pix_valid;
    anim_state_e anim_state;
    logic busy;
    modport master (
`ifdef PLAYER_MIRROR_EN
        output facing_left,
`endif
        output frame_tick, throw_req, hit_req, hcount, vcount, xpos, ypos,
        input rom_addr, pix_valid, anim_state, busy
    );
    modport slave (
`ifdef PLAYER_MIRROR_EN
        input facing_left,
`endif
        input frame_tick, throw_req, hit_req, hcount, vcount, xpos, ypos,
        output rom_addr, pix_valid, anim_state, busy
    );
endinterface

// File: rtl/player_anim_ctrl_addr_gen.sv
// sprite_addr_gen: two-stage raster-to-ROM address pipeline with optional horizontal flip.
module sprite_addr_gen
    import players_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic [10:0]       xpos_l,
    input  logic [10:0]       ypos_l,
    input  anim_state_e       state,
    input  logic              mirror,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              pix_valid
);
    logic signed [11:0] dx_d, dx_q, dy_d, dy_q;
    logic inb_d, inb_q, pv_q;
    logic [ROM_AW-1:0] col, addr_d, addr_q;

    always_comb begin
        dx_d = $signed({1'b0, hcount}) - $signed({1'b0, xpos_l});
        dy_d = $signed({1'b0, vcount}) - $signed({1'b0, ypos_l});
        inb_d = !dx_d[11] && !dy_d[11] && dx_d < 12'(IMG_W) && dy_d < 12'(IMG_H);
        col = mirror ? ROM_AW'(IMG_W - 1) - ROM_AW'(dx_q) : ROM_AW'(dx_q);
        addr_d = inb_q ? base(state) + ROM_AW'(dy_q) * ROM_AW'(IMG_W) + col : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
            inb_q <= 1'b0;
            addr_q <= '0;
            pv_q <= 1'b0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            inb_q <= inb_d;
            addr_q <= addr_d;
            pv_q <= inb_q;
        end
    end

    assign rom_addr = addr_q;
    assign pix_valid = pv_q;
endmodule

// File: rtl/player_anim_ctrl.sv
// player_anim_ctrl: per-player animation FSM advancing on frame ticks, feeding the sprite address pipeline.
// PLAYER_MIRROR_EN enables the facing_left horizontal flip.
module player_anim_ctrl
    import players_pkg::*;
#(
    parameter int THROW_FRAMES = 12,
    parameter int HIT_FRAMES = 20
) (
    input logic clk,
    input logic rst,
    player_anim_ctrl_if.slave bus
);
    anim_state_e state_d, state_q;
    logic [7:0] cnt_d, cnt_q;
    logic pend_hit_d, pend_hit_q, pend_throw_d, pend_throw_q;
    logic [10:0] xpos_l_d, xpos_l_q, ypos_l_d, ypos_l_q;
    logic mirror_d, mirror_q;

    always_comb begin
        // A request landing on the tick cycle is kept for the following tick.
        pend_hit_d = bus.frame_tick ? bus.hit_req : pend_hit_q | bus.hit_req;
        pend_throw_d = bus.frame_tick ? bus.throw_req : pend_throw_q | bus.throw_req;
        xpos_l_d = bus.frame_tick ? bus.xpos : xpos_l_q;
        ypos_l_d = bus.frame_tick ? bus.ypos : ypos_l_q;
`ifdef PLAYER_MIRROR_EN
        mirror_d = bus.frame_tick ? bus.facing_left : mirror_q;
`else
        mirror_d = 1'b0;
`endif
        state_d = state_q;
        cnt_d = cnt_q;
        if (bus.frame_tick) begin
            if (pend_hit_q && state_q != HIT) begin
                state_d = HIT;
                cnt_d = 8'(HIT_FRAMES - 1);
            end else if (state_q == IDLE) begin
                if (pend_throw_q) begin
                    state_d = THROW;
                    cnt_d = 8'(THROW_FRAMES - 1);
                end
            end else if (cnt_q == 8'd0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            pend_hit_q <= 1'b0;
            pend_throw_q <= 1'b0;
            xpos_l_q <= '0;
            ypos_l_q <= '0;
            mirror_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pend_hit_q <= pend_hit_d;
            pend_throw_q <= pend_throw_d;
            xpos_l_q <= xpos_l_d;
            ypos_l_q <= ypos_l_d;
            mirror_q <= mirror_d;
        end
    end

    assign bus.anim_state = state_q;
    assign bus.busy = state_q != IDLE;

    sprite_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .hcount    (bus.hcount),
        .vcount    (bus.vcount),
        .xpos_l    (xpos_l_q),
        .ypos_l    (ypos_l_q),
        .state     (state_q),
        .mirror    (mirror_q),
        .rom_addr  (bus.rom_addr),
        .pix_valid (bus.pix_valid)
    );
endmodule

// File: tb/tb_player_anim_ctrl.sv
// tb_player_anim_ctrl: directed and randomized checks of player_anim_ctrl against a tick-counting reference model.
module tb_player_anim_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    player_anim_ctrl_if bus ();
    player_anim_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {bit v; int a; bit p;} exp_t;
    exp_t q[$];
    int m_st = 0, m_enter = 0, m_t = 0, m_xl = 0, m_yl = 0;
    bit m_ph = 0, m_pt = 0, m_fl = 0, r_prev = 0, d_fl = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t expect_pix(int hc, int vc);
        exp_t e;
        int dx = hc - m_xl, dy = vc - m_yl;
        e.v = 1;
        e.p = dx >= 0 && dy >= 0 && dx < 140 && dy < 151;
        e.a = e.p ? m_st * 21140 + dy * 140 + (m_fl ? 139 - dx : dx) : 0;
        return e;
    endfunction

    task automatic cyc(input bit r, input bit tk, input bit th, input bit hi,
                       input int hc, input int vc, input int xp, input int yp, input bit fl);
        exp_t e;
        @(negedge clk);
        chk("state", 32'(bus.anim_state), m_st);
        chk("busy", bus.busy, m_st != 0);
        if (r_prev) begin
            chk("rst_addr", bus.rom_addr, 0);
            chk("rst_valid", bus.pix_valid, 0);
        end
        if (q.size() == 2) begin
            e = q.pop_front();
            if (e.v) begin
                chk("addr", bus.rom_addr, e.a);
                chk("valid", bus.pix_valid, e.p);
            end
        end
        rst = r;
        bus.frame_tick = tk;
        bus.throw_req = th;
        bus.hit_req = hi;
        bus.hcount = 11'(hc);
        bus.vcount = 11'(vc);
        bus.xpos = 11'(xp);
        bus.ypos = 11'(yp);
`ifdef PLAYER_MIRROR_EN
        bus.facing_left = fl;
`endif
        r_prev = r;
        if (r) begin
            m_st = 0; m_ph = 0; m_pt = 0; m_xl = 0; m_yl = 0; m_fl = 0;
            q.delete();
            e.v = 1; e.a = 0; e.p = 0;
            q.push_back(e);
        end else begin
            e = expect_pix(hc & 2047, vc & 2047);
            e.v = !tk;
            q.push_back(e);
            if (tk) begin
                m_t++;
                if (m_st == 0) begin
                    if (m_ph) begin m_st = 2; m_enter = m_t; end
                    else if (m_pt) begin m_st = 1; m_enter = m_t; end
                end else if (m_st == 1) begin
                    if (m_ph) begin m_st = 2; m_enter = m_t; end
                    else if (m_t - m_enter == 12) m_st = 0;
                end else if (m_t - m_enter == 20) m_st = 0;
                m_ph = hi; m_pt = th;
                m_xl = xp & 2047; m_yl = yp & 2047;
`ifdef PLAYER_MIRROR_EN
                m_fl = fl;
`endif
            end else begin
                m_ph |= hi; m_pt |= th;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 100, 50, d_fl);
    endtask

    task automatic tick();
        cyc(0, 1, 0, 0, 0, 0, 100, 50, d_fl);
    endtask

    task automatic pt(input string tag, input int hc, input int vc, input int xp, input int ea, input bit ep);
        repeat (3) cyc(0, 0, 0, 0, hc, vc, xp, 50, d_fl);
        chk({tag, "_addr"}, bus.rom_addr, ea);
        chk({tag, "_valid"}, bus.pix_valid, ep);
    endtask

    initial begin
        bus.frame_tick = 0; bus.throw_req = 0; bus.hit_req = 0;
        bus.hcount = 0; bus.vcount = 0; bus.xpos = 0; bus.ypos = 0;
`ifdef PLAYER_MIRROR_EN
        bus.facing_left = 0;
`endif
        repeat (2) @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        tick();
        pt("origin", 100, 50, 100, 0, 1);
        pt("corner", 239, 200, 100, 21139, 1);
        cyc(0, 0, 1, 0, 0, 0, 100, 50, 0);
        tick();
        pt("throw_base", 100, 50, 100, 21140, 1);
        repeat (11) tick();
        idle();
        chk("throw_hold", 32'(bus.anim_state), 1);
        tick();
        idle();
        chk("throw_end", 32'(bus.anim_state), 0);
        cyc(0, 0, 1, 1, 0, 0, 100, 50, 0);
        tick();
        repeat (19) tick();
        idle();
        chk("hit_hold", 32'(bus.anim_state), 2);
        tick();
        idle();
        chk("hit_end", 32'(bus.anim_state), 0);
        cyc(0, 0, 1, 0, 0, 0, 100, 50, 0);
        tick();
        repeat (4) tick();
        cyc(0, 0, 0, 1, 0, 0, 100, 50, 0);
        tick();
        pt("hit_base", 100, 50, 100, 42280, 1);
        cyc(0, 0, 1, 0, 0, 0, 100, 50, 0);
        repeat (19) tick();
        idle();
        chk("preempt_hold", 32'(bus.anim_state), 2);
        tick();
        idle();
        chk("preempt_end", 32'(bus.anim_state), 0);
        pt("left", 99, 50, 100, 0, 0);
        pt("right", 240, 50, 100, 0, 0);
        pt("below", 100, 201, 100, 0, 0);
        pt("midmove", 100, 50, 500, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 100, 50, 0);
        tick();
        idle();
        cyc(1, 0, 0, 0, 0, 0, 100, 50, 0);
        idle();
        chk("rst_state", 32'(bus.anim_state), 0);
`ifdef PLAYER_MIRROR_EN
        d_fl = 1;
        tick();
        pt("mirror", 100, 50, 100, 139, 1);
        d_fl = 0;
`endif
        for (int f = 0; f < 300; f++) begin
            int len = int'($urandom_range(10, 40));
            int bx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 1100));
            int by = int'($urandom_range(0, 800));
            bit bf = 1'($urandom_range(0, 1));
            for (int c = 0; c < len; c++) begin
                bit tk = (c == len - 1);
                bit th = ($urandom_range(0, 29) == 0);
                bit hi = ($urandom_range(0, 59) == 0);
                bit r = ($urandom_range(0, 2999) == 0);
                int hc = (m_xl + int'($urandom_range(0, 149)) - 5) & 2047;
                int vc = (m_yl + int'($urandom_range(0, 160)) - 5) & 2047;
                int xp = tk ? bx : int'($urandom_range(0, 2047));
                int yp = tk ? by : int'($urandom_range(0, 2047));
                cyc(r, tk && !r, th && !r, hi && !r, hc, vc, xp, yp, tk ? bf : 1'($urandom_range(0, 1)));
            end
        end
        repeat (3) idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
